// File: rtl/mac_serial_host.sv
// -----------------------------------------------------------------------------
// mac_serial_host
//
// Host-side driver for the MAC chip pin protocol. A parallel operand pair is
// taken over a valid/ready handshake, announced to the chip with a one-cycle
// START pulse, then shifted out LSB first on two serial pins. The block then
// waits for the chip's Finish pin and deserializes the RES_W-bit result
// (LSB first) plus the carry bit, reporting it with a one-cycle res_valid.
//
// Parameters:
//   OP_W     operand width / length of the serial operand burst
//   RES_W    result width / length of the serial result burst
//   TIMEOUT  max cycles spent waiting for Finish before aborting with res_err
//
// Ports:
//   clock, reset            system clock, synchronous active-high reset
//   op_valid/op_ready       operand handshake (ready only while idle)
//   op_a, op_b              operands
//   chip_start              -> chip io_in[11]  (START)
//   chip_ser_a, chip_ser_b  -> chip io_in[10], io_in[9]  (serial operands)
//   chip_finish             <- chip io_out[10] (Finish)
//   chip_ser_res            <- chip io_out[9]  (serial result)
//   chip_carry              <- chip io_out[11] (carry)
//   res_valid               one-cycle pulse, result fields valid
//   res_data, res_carry     result and carry, held until next res_valid
//   res_err                 1 = timeout or early Finish drop
//   res_parity              (only with MAC_HOST_PARITY_EN) XOR of {carry,data}
//   busy                    high whenever not idle
//
// Optional feature macro: MAC_HOST_PARITY_EN adds the res_parity output.
// -----------------------------------------------------------------------------
module mac_serial_host #(
  parameter int OP_W    = 8,
  parameter int RES_W   = 20,
  parameter int TIMEOUT = 1023
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [OP_W-1:0]  op_a,
  input  logic [OP_W-1:0]  op_b,
  output logic             chip_start,
  output logic             chip_ser_a,
  output logic             chip_ser_b,
  input  logic             chip_finish,
  input  logic             chip_ser_res,
  input  logic             chip_carry,
  output logic             res_valid,
  output logic [RES_W-1:0] res_data,
  output logic             res_carry,
  output logic             res_err,
`ifdef MAC_HOST_PARITY_EN
  output logic             res_parity,
`endif
  output logic             busy
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_SHIFT = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_RECV  = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  localparam int BIT_W = (OP_W > 1) ? $clog2(OP_W) : 1;
  localparam int IDX_W = (RES_W > 1) ? $clog2(RES_W) : 1;
  localparam int TO_W  = $clog2(TIMEOUT + 1);

  logic [2:0]       r_state;
  logic [OP_W-1:0]  r_sh_a;
  logic [OP_W-1:0]  r_sh_b;
  logic [BIT_W-1:0] r_bit;
  logic [IDX_W-1:0] r_idx;
  logic [TO_W-1:0]  r_to_cnt;
  logic             r_chip_start;
  logic             r_ser_a;
  logic             r_ser_b;

  // Result accumulation happens in r_acc*; the visible result registers are
  // only loaded on the transition into DONE so they stay stable otherwise.
  logic [RES_W-1:0] r_acc;
  logic             r_acc_carry;
  logic             r_res_valid;
  logic [RES_W-1:0] r_res_data;
  logic             r_res_carry;
  logic             r_res_err;

  logic [RES_W-1:0] w_acc_ins;

`ifdef MAC_HOST_PARITY_EN
  logic r_acc_par;
  logic r_res_par;
  logic w_par_ins;
  assign w_par_ins  = r_acc_par ^ chip_ser_res;
  assign res_parity = r_res_par;
`endif

  // Accumulator with the current serial bit dropped into slot r_idx; used
  // both for the running value and for the final bit of the burst.
  always_comb begin
    w_acc_ins        = r_acc;
    w_acc_ins[r_idx] = chip_ser_res;
  end

  always_ff @(posedge clock) begin
    r_res_valid <= 1'b0;
    if (reset) begin
      r_state      <= S_IDLE;
      r_sh_a       <= '0;
      r_sh_b       <= '0;
      r_bit        <= '0;
      r_idx        <= '0;
      r_to_cnt     <= '0;
      r_chip_start <= 1'b0;
      r_ser_a      <= 1'b0;
      r_ser_b      <= 1'b0;
      r_acc        <= '0;
      r_acc_carry  <= 1'b0;
      r_res_data   <= '0;
      r_res_carry  <= 1'b0;
      r_res_err    <= 1'b0;
`ifdef MAC_HOST_PARITY_EN
      r_acc_par    <= 1'b0;
      r_res_par    <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (op_valid) begin
            r_sh_a       <= op_a;
            r_sh_b       <= op_b;
            r_acc        <= '0;
            r_acc_carry  <= 1'b0;
`ifdef MAC_HOST_PARITY_EN
            r_acc_par    <= 1'b0;
`endif
            r_chip_start <= 1'b1;
            r_state      <= S_START;
          end
        end

        S_START: begin
          // Present bit 0 for the first SHIFT cycle.
          r_chip_start <= 1'b0;
          r_ser_a      <= r_sh_a[0];
          r_ser_b      <= r_sh_b[0];
          r_sh_a       <= r_sh_a >> 1;
          r_sh_b       <= r_sh_b >> 1;
          r_bit        <= '0;
          r_state      <= S_SHIFT;
        end

        S_SHIFT: begin
          if (r_bit == BIT_W'(OP_W - 1)) begin
            r_ser_a  <= 1'b0;
            r_ser_b  <= 1'b0;
            r_to_cnt <= '0;
            r_state  <= S_WAIT;
          end else begin
            r_ser_a <= r_sh_a[0];
            r_ser_b <= r_sh_b[0];
            r_sh_a  <= r_sh_a >> 1;
            r_sh_b  <= r_sh_b >> 1;
            r_bit   <= r_bit + BIT_W'(1);
          end
        end

        S_WAIT: begin
          // Finish is checked first so a Finish on the last allowed cycle
          // still wins over the timeout.
          if (chip_finish) begin
            r_acc       <= {{(RES_W-1){1'b0}}, chip_ser_res};
            r_acc_carry <= chip_carry;
`ifdef MAC_HOST_PARITY_EN
            r_acc_par   <= chip_carry ^ chip_ser_res;
`endif
            r_idx       <= IDX_W'(1);
            r_state     <= S_RECV;
          end else if (r_to_cnt == TO_W'(TIMEOUT - 1)) begin
            r_res_data  <= '0;
            r_res_carry <= 1'b0;
            r_res_err   <= 1'b1;
`ifdef MAC_HOST_PARITY_EN
            r_res_par   <= 1'b0;
`endif
            r_res_valid <= 1'b1;
            r_state     <= S_DONE;
          end else begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
          end
        end

        S_RECV: begin
          if (chip_finish) begin
            if (r_idx == IDX_W'(RES_W - 1)) begin
              r_res_data  <= w_acc_ins;
              r_res_carry <= r_acc_carry;
              r_res_err   <= 1'b0;
`ifdef MAC_HOST_PARITY_EN
              r_res_par   <= w_par_ins;
`endif
              r_res_valid <= 1'b1;
              r_state     <= S_DONE;
            end else begin
              r_acc     <= w_acc_ins;
`ifdef MAC_HOST_PARITY_EN
              r_acc_par <= w_par_ins;
`endif
              r_idx     <= r_idx + IDX_W'(1);
            end
          end else begin
            // Finish dropped early: report what arrived, flagged as error.
            r_res_data  <= r_acc;
            r_res_carry <= r_acc_carry;
            r_res_err   <= 1'b1;
`ifdef MAC_HOST_PARITY_EN
            r_res_par   <= r_acc_par;
`endif
            r_res_valid <= 1'b1;
            r_state     <= S_DONE;
          end
        end

        S_DONE: begin
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign op_ready   = (r_state == S_IDLE);
  assign busy       = (r_state != S_IDLE);
  assign chip_start = r_chip_start;
  assign chip_ser_a = r_ser_a;
  assign chip_ser_b = r_ser_b;
  assign res_valid  = r_res_valid;
  assign res_data   = r_res_data;
  assign res_carry  = r_res_carry;
  assign res_err    = r_res_err;

endmodule
